arp_scheduler: RTL and testbench

Note scheduler that sits between the raw 12-key keyboard scanner and the keyboard-to-half-period lookup table in the synthesizer. When several keys are held, it time-multiplexes the single tone path by presenting one one-hot key code at a time to the lookup table, stepping round-robin (arpeggio) through held keys. When arpeggiation is disabled, it acts as a mono priority selector. Its output drives the lookup table's 12-bit key input directly; gate and note_start go to the envelope/output stage.

---
 rtl/arp_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_arp_scheduler.sv | 137 +++++++++++++
 2 files changed

// File: rtl/arp_scheduler.sv
// Arpeggiator / mono priority selector from a 12-key held bitmap to a one-hot lookup-table key code.
// Latency: keys -> key_onehot 2 cycles (input register + output register); no backpressure, free-running.
module arp_scheduler #(
    parameter int NUM_KEYS = 12,
    parameter int STEP_W   = 26
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                arp_en,
    input  logic [1:0]          mode,
    input  logic [STEP_W-1:0]   step_len,
    output logic [NUM_KEYS-1:0] key_onehot,
    output logic                gate,
    output logic                note_start
);

    localparam int IW = $clog2(NUM_KEYS);
    localparam logic [1:0] M_UP = 2'b00, M_DOWN = 2'b01, M_UPDN = 2'b10;

    typedef enum logic {IDLE, PLAY} state_t;

    function automatic logic [IW-1:0] f_lowest(input logic [NUM_KEYS-1:0] m);
        logic [IW-1:0] r;
        r = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) if (m[i]) r = IW'(i);
        return r;
    endfunction

    function automatic logic [IW-1:0] f_highest(input logic [NUM_KEYS-1:0] m);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_KEYS; i++) if (m[i]) r = IW'(i);
        return r;
    endfunction

    // Circular search; farthest candidate first so the nearest held key wins.
    function automatic logic [IW-1:0] f_circ(input logic [NUM_KEYS-1:0] m,
                                             input logic [IW-1:0] c, input logic asc);
        logic [IW-1:0] r;
        logic [IW-1:0] ii;
        int            idx;
        r = c;
        for (int k = NUM_KEYS - 1; k >= 1; k--) begin
            idx = asc ? (int'(c) + k) % NUM_KEYS : (int'(c) - k + NUM_KEYS) % NUM_KEYS;
            ii  = IW'(idx);
            if (m[ii]) r = ii;
        end
        return r;
    endfunction

    // Non-wrapping search; returns {found, index}.
    function automatic logic [IW:0] f_lin(input logic [NUM_KEYS-1:0] m,
                                          input logic [IW-1:0] c, input logic asc);
        logic [IW:0]   r;
        logic [IW-1:0] ii;
        int            idx;
        r = '0;
        for (int k = NUM_KEYS - 1; k >= 1; k--) begin
            idx = asc ? int'(c) + k : int'(c) - k;
            if (idx >= 0 && idx < NUM_KEYS) begin
                ii = IW'(idx);
                if (m[ii]) r = {1'b1, ii};
            end
        end
        return r;
    endfunction

    state_t              r_state, w_state_n;
    logic [NUM_KEYS-1:0] r_keys_q;
    logic [IW-1:0]       r_idx, w_idx_n;
    logic                r_dir, w_dir_n;          // 0 = up (index descending), 1 = down
    logic [STEP_W-1:0]   r_cnt, w_cnt_n;
    logic [STEP_W-1:0]   r_stepm1, w_stepm1_n;
    logic [1:0]          r_mode, w_mode_n;
    logic [NUM_KEYS-1:0] r_onehot, w_onehot_n;
    logic                r_gate, w_gate_n;
    logic                r_start, w_start_n;

    logic                w_any;
    logic [1:0]          w_mode_in;
    logic [STEP_W-1:0]   w_stepm1_in;
    logic [IW-1:0]       w_low, w_adv_idx;
    logic                w_dir_base, w_adv_dir;
    logic [IW:0]         w_lin_a, w_lin_b;
    logic [NUM_KEYS-1:0] w_one;

    assign w_any       = |r_keys_q;
    assign w_mode_in   = (mode == 2'b11) ? M_UP : mode;
    assign w_stepm1_in = (step_len == '0) ? '0 : step_len - STEP_W'(1);
    assign w_low       = f_lowest(r_keys_q);
    assign w_one       = {{(NUM_KEYS-1){1'b0}}, 1'b1};
    assign w_dir_base  = (w_mode_in != r_mode) ? 1'b0 : r_dir;

    // Next key on an advance, using the mode sampled at this advance.
    always_comb begin
        w_adv_idx = r_idx;
        w_adv_dir = w_dir_base;
        w_lin_a   = f_lin(r_keys_q, r_idx, w_dir_base);
        w_lin_b   = f_lin(r_keys_q, r_idx, ~w_dir_base);
        case (w_mode_in)
            M_DOWN: w_adv_idx = f_circ(r_keys_q, r_idx, 1'b1);
            M_UPDN: begin
                if (w_lin_a[IW]) begin
                    w_adv_idx = w_lin_a[IW-1:0];
                end else if (w_lin_b[IW]) begin
                    w_adv_idx = w_lin_b[IW-1:0];
                    w_adv_dir = ~w_dir_base;
                end
            end
            default: w_adv_idx = f_circ(r_keys_q, r_idx, 1'b0);
        endcase
    end

    always_comb begin
        w_state_n  = r_state;
        w_idx_n    = r_idx;
        w_dir_n    = r_dir;
        w_cnt_n    = r_cnt;
        w_stepm1_n = r_stepm1;
        w_mode_n   = r_mode;
        w_onehot_n = r_onehot;
        w_gate_n   = r_gate;
        w_start_n  = 1'b0;
        if (!arp_en) begin
            w_state_n  = w_any ? PLAY : IDLE;
            w_idx_n    = w_any ? w_low : r_idx;
            w_dir_n    = 1'b0;
            w_cnt_n    = '0;
            w_stepm1_n = w_stepm1_in;
            w_mode_n   = w_mode_in;
            w_onehot_n = w_any ? (w_one << w_low) : '0;
            w_gate_n   = w_any;
            w_start_n  = w_any && (w_onehot_n != r_onehot);
        end else begin
            case (r_state)
                IDLE: begin
                    w_onehot_n = '0;
                    w_gate_n   = 1'b0;
                    if (w_any) begin
                        w_state_n  = PLAY;
                        w_idx_n    = (w_mode_in == M_DOWN) ? w_low : f_highest(r_keys_q);
                        w_dir_n    = 1'b0;
                        w_cnt_n    = '0;
                        w_stepm1_n = w_stepm1_in;
                        w_mode_n   = w_mode_in;
                        w_onehot_n = w_one << w_idx_n;
                        w_gate_n   = 1'b1;
                        w_start_n  = 1'b1;
                    end
                end
                default: begin
                    if (!w_any) begin
                        w_state_n  = IDLE;
                        w_cnt_n    = '0;
                        w_onehot_n = '0;
                        w_gate_n   = 1'b0;
                    end else if (!r_keys_q[r_idx] || r_cnt == r_stepm1) begin
                        w_idx_n    = w_adv_idx;
                        w_dir_n    = w_adv_dir;
                        w_cnt_n    = '0;
                        w_stepm1_n = w_stepm1_in;
                        w_mode_n   = w_mode_in;
                        w_onehot_n = w_one << w_adv_idx;
                        w_gate_n   = 1'b1;
                        w_start_n  = 1'b1;
                    end else begin
                        w_cnt_n    = r_cnt + STEP_W'(1);
                        w_onehot_n = w_one << r_idx;
                        w_gate_n   = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_keys_q <= '0;
            r_idx    <= IW'(NUM_KEYS - 1);
            r_dir    <= 1'b0;
            r_cnt    <= '0;
            r_stepm1 <= '0;
            r_mode   <= M_UP;
            r_onehot <= '0;
            r_gate   <= 1'b0;
            r_start  <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_keys_q <= keys;
            r_idx    <= w_idx_n;
            r_dir    <= w_dir_n;
            r_cnt    <= w_cnt_n;
            r_stepm1 <= w_stepm1_n;
            r_mode   <= w_mode_n;
            r_onehot <= w_onehot_n;
            r_gate   <= w_gate_n;
            r_start  <= w_start_n;
        end
    end

    assign key_onehot = r_onehot;
    assign gate       = r_gate;
    assign note_start = r_start;

endmodule

// File: tb/tb_arp_scheduler.sv
// Directed bench for arp_scheduler: expected outputs queued per cycle, popped and checked after each edge.
module tb_arp_scheduler;

    logic        clock = 1'b0;
    logic        resetn;
    logic [11:0] keys;
    logic        arp_en;
    logic [1:0]  mode;
    logic [25:0] step_len;
    logic [11:0] key_onehot;
    logic        gate;
    logic        note_start;

    int vectors     = 0;
    int miscompares = 0;
    logic [13:0] exp_q[$];

    arp_scheduler #(.NUM_KEYS(12), .STEP_W(26)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .keys       (keys),
        .arp_en     (arp_en),
        .mode       (mode),
        .step_len   (step_len),
        .key_onehot (key_onehot),
        .gate       (gate),
        .note_start (note_start)
    );

    always #5 clock = ~clock;

    task automatic exp1(input logic [11:0] oh, input logic g, input logic s, input string tag);
        logic [13:0] e;
        exp_q.push_back({oh, g, s});
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        vectors++;
        assert ({key_onehot, gate, note_start} === e) else begin
            miscompares++;
            $error("FAIL %s: observed oh=%h gate=%b start=%b, expected oh=%h gate=%b start=%b",
                   tag, key_onehot, gate, note_start, e[13:2], e[1], e[0]);
        end
        vectors++;
        assert ($onehot0(key_onehot)) else begin
            miscompares++;
            $error("FAIL %s_onehot: observed oh=%h, expected at most one bit set", tag, key_onehot);
        end
    endtask

    task automatic exp_seq(input logic [11:0] oh, input int n, input string tag);
        for (int i = 0; i < n; i++) exp1(oh, 1'b1, (i == 0), tag);
    endtask

    task automatic do_reset(input string tag);
        resetn = 1'b0;
        keys   = '0;
        exp1(12'h000, 1'b0, 1'b0, tag);
        resetn = 1'b1;
    endtask

    task automatic setup(input logic en, input logic [1:0] m, input logic [25:0] sl,
                         input logic [11:0] k);
        arp_en   = en;
        mode     = m;
        step_len = sl;
        keys     = k;
        exp1(12'h000, 1'b0, 1'b0, "lat1");
    endtask

    initial begin
        resetn = 1'b0; keys = '0; arp_en = 1'b1; mode = 2'b00; step_len = 26'd4;
        @(posedge clock);
        do_reset("reset");

        // up, two keys, dwell 4
        setup(1'b1, 2'b00, 26'd4, 12'h801);
        for (int r = 0; r < 2; r++) begin
            exp_seq(12'h800, 4, "up_hi");
            exp_seq(12'h001, 4, "up_lo");
        end

        // up-down ping-pong over {11,5,0}
        do_reset("reset2");
        setup(1'b1, 2'b10, 26'd2, 12'h821);
        exp_seq(12'h800, 2, "ud11");
        exp_seq(12'h020, 2, "ud5a");
        exp_seq(12'h001, 2, "ud0");
        exp_seq(12'h020, 2, "ud5b");
        exp_seq(12'h800, 2, "ud11b");
        exp_seq(12'h020, 2, "ud5c");
        exp_seq(12'h001, 2, "ud0b");

        // single key, down mode, repeats with fresh note_start
        do_reset("reset3");
        setup(1'b1, 2'b01, 26'd3, 12'h020);
        for (int r = 0; r < 3; r++) exp_seq(12'h020, 3, "single");

        // release current key mid-dwell, then release all
        do_reset("reset4");
        setup(1'b1, 2'b00, 26'd4, 12'h821);
        exp_seq(12'h800, 2, "rel_pre");
        keys = 12'h021;
        exp1(12'h800, 1'b1, 1'b0, "rel_lag");
        exp_seq(12'h020, 4, "rel_next");
        exp1(12'h001, 1'b1, 1'b1, "rel_wrap");
        keys = 12'h000;
        exp1(12'h001, 1'b1, 1'b0, "off_lag");
        exp1(12'h000, 1'b0, 1'b0, "off_idle");
        exp1(12'h000, 1'b0, 1'b0, "off_idle2");

        // step_len 0 acts as 1, then reset mid-sequence
        do_reset("reset5");
        setup(1'b1, 2'b00, 26'd0, 12'h801);
        for (int r = 0; r < 3; r++) begin
            exp1(12'h800, 1'b1, 1'b1, "step0_hi");
            exp1(12'h001, 1'b1, 1'b1, "step0_lo");
        end
        do_reset("reset_mid");

        // mono priority, then hand over to the arpeggiator
        setup(1'b0, 2'b00, 26'd2, 12'h0A0);
        exp_seq(12'h020, 2, "mono5");
        keys = 12'h0A2;
        exp1(12'h020, 1'b1, 1'b0, "mono_lag");
        exp_seq(12'h002, 2, "mono1");
        arp_en = 1'b1;
        exp1(12'h002, 1'b1, 1'b0, "arp_hold");
        exp_seq(12'h080, 2, "arp7");
        exp_seq(12'h020, 2, "arp5");
        exp_seq(12'h002, 2, "arp1");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
